issue_select_unit: RTL and testbench
====================================

// Module: issue_select_unit
// PURPOSE
//  Select stage of the out-of-order backend. Consumes the per-RS-entry request vector from the wakeup
//  logic and grants one ready entry per cycle, round-robin. It returns grant_en/grant_index to the
//  wakeup logic, which marks the entry selected, and to execute, which reads the entry and issues it.
//  Grants are gated by per-FU availability from execute.
// PARAMETERS
//  NUM_ROWS   RS_ENTRIES      number of reservation-station entries / request bits
//  NUM_FUS    NUM_FUS         number of functional units
//  IDX_W      $clog2(NUM_ROWS) entry index width
//  FU_W       $clog2(NUM_FUS)  FU index width (min 1)
// PORTS
//  clk            in   1               clock
//  rst            in   1               reset, synchronous, active-high
//  flush          in   1               pipeline flush; kills any grant
//  request_vector in   NUM_ROWS        bit j = entry j ready to issue (from wakeup)
//  entry_fu       in   NUM_ROWS*FU_W   FU id of entry j at [j*FU_W +: FU_W]
//  fu_ready       in   NUM_FUS         bit f = FU f can accept an op this cycle
//  grant_en       out  1               registered, single-cycle grant pulse
//  grant_index    out  IDX_W           granted entry (valid when grant_en)
//  grant_fu       out  FU_W            FU of the granted entry (valid when grant_en)
//  perf_grant_cnt out  32              grants issued (see CONFIGURATION)
//  perf_block_cnt out  32              cycles lost to FU backpressure (see CONFIGURATION)
// BEHAVIOUR
//  - State: rr_ptr (IDX_W), grant_en/grant_index/grant_fu registers.
//  - eligible[j] = request_vector[j] & (entry_fu[j] < NUM_FUS) & fu_ready[entry_fu[j]]
//      & ~(grant_en & grant_index==j). The last term masks the entry granted last cycle. Wakeup clears
//      that entry's request one cycle late, so without the mask it would be double-granted.
//  - Pick: the first eligible j scanning rr_ptr, rr_ptr+1, ... mod NUM_ROWS. Wrap is correct for
//    non-power-of-2 NUM_ROWS.
//  - Latency: inputs sampled in cycle t; grant visible in cycle t+1. No combinational path from inputs
//    to outputs.
//  - On a grant: grant_en<=1, grant_index<=j, grant_fu<=entry_fu[j], rr_ptr<=(j+1) mod NUM_ROWS.
//  - No eligible entry: grant_en<=0, rr_ptr holds, grant_index/grant_fu hold their last value.
//  - entry_fu >= NUM_FUS: the entry is never eligible.
//  - flush: next cycle grant_en=0 and rr_ptr=0, whatever the requests. flush beats any grant.
//  - Reset (also mid-operation): grant_en=0, grant_index=0, grant_fu=0, rr_ptr=0, perf counters=0.
//  - At most one grant per cycle. An entry whose request drops stays ungranted. No memory of a pending
//    request.
// CONFIGURATION
//  SELECT_PERF_CNT_EN defined:
//    perf_grant_cnt +1 each cycle grant_en is set.
//    perf_block_cnt +1 each cycle with (request_vector != 0) and no eligible entry due to fu_ready.
//    Both counters saturate at 32'hFFFF_FFFF and clear on rst.
//  SELECT_PERF_CNT_EN undefined: both perf ports still exist, tied to 0. No counter flops.
// STRUCTURE
//  - CORE_PKG: RS_ENTRIES, NUM_FUS, rs_idx_t (IDX_W), fu_idx_t (FU_W).
//  - Sub-module rr_arbiter (#N): req[N] + ptr -> gnt_valid, gnt_idx; purely combinational
//    rotate/priority-encode/unrotate. Also reused by the memory issue path.
//  - This module: eligibility mask, rr_ptr, output registers, optional counters.
// TESTING
//  1. rst for 2 cycles with request_vector=8'hFF -> grant_en=0, grant_index=0, perf counters 0.
//  2. NUM_ROWS=8, request=8'b0000_0101 held, fu_ready all 1 -> grant_index 0,2,0,2 on consecutive
//     cycles.
//  3. request=8'b0000_0010 held -> grant idx1 at t+1, grant_en=0 at t+2 (mask), idx1 again at t+3.
//  4. entry3 only, entry_fu[3]=1, fu_ready=2'b01 for 3 cycles -> no grant, perf_block_cnt=3;
//     fu_ready=2'b11 -> grant idx3 next cycle.
//  5. rr_ptr=7 (after granting 6), request bits 7 and 1 -> grants 7 then 1 (wrap).
//  6. flush asserted with request=8'hFF -> grant_en=0 next cycle; the following grant is idx0
//     (rr_ptr reset).

Source files
------------

// File: rtl/issue_select_unit_pkg.sv
// Shared types and sizing for the issue select stage.
package issue_select_unit_pkg;

  localparam int unsigned RS_ENTRIES = 8;
  localparam int unsigned NUM_FUS    = 2;
  localparam int unsigned IDX_W      = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
  localparam int unsigned FU_W       = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

  typedef logic [IDX_W-1:0] rs_idx_t;
  typedef logic [FU_W-1:0]  fu_idx_t;

  // Successor of an entry index, wrapping at RS_ENTRIES (works for non-power-of-2 sizes).
  function automatic rs_idx_t next_idx(rs_idx_t idx);
    if (32'(idx) == RS_ENTRIES - 1) begin
      return '0;
    end
    return rs_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/issue_select_unit_if.sv
// Request/grant bundle between wakeup/execute (master) and the select stage (slave).
interface issue_select_unit_if;
  import issue_select_unit_pkg::*;

  logic                         flush;
  logic [RS_ENTRIES-1:0]        request_vector;
  logic [RS_ENTRIES*FU_W-1:0]   entry_fu;
  logic [NUM_FUS-1:0]           fu_ready;
  logic                         grant_en;
  rs_idx_t                      grant_index;
  fu_idx_t                      grant_fu;
  logic [31:0]                  perf_grant_cnt;
  logic [31:0]                  perf_block_cnt;

  modport master (
    output flush, request_vector, entry_fu, fu_ready,
    input  grant_en, grant_index, grant_fu, perf_grant_cnt, perf_block_cnt
  );

  modport slave (
    input  flush, request_vector, entry_fu, fu_ready,
    output grant_en, grant_index, grant_fu, perf_grant_cnt, perf_block_cnt
  );

endinterface

// File: rtl/issue_select_unit_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr, wrapping mod N.
// Shared with the memory issue path.
module issue_select_unit_rr_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            gnt_valid,
  output logic [IdxW-1:0] gnt_idx
);

  int unsigned pos;

  // Rotate by ptr, priority-encode, and map back to an absolute index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!gnt_valid && req[IdxW'(pos)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/issue_select_unit.sv
// Issue select stage: grants one ready, FU-available RS entry per cycle in round-robin order.
// Optional perf counters enabled by defining SELECT_PERF_CNT_EN.
module issue_select_unit
  import issue_select_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  issue_select_unit_if.slave  bus
);

  rs_idx_t               rr_ptr_q;
  logic                  grant_en_q;
  rs_idx_t               grant_index_q;
  fu_idx_t               grant_fu_q;

  logic [RS_ENTRIES-1:0] eligible;
  fu_idx_t               fu_sel;
  logic                  arb_valid;
  rs_idx_t               arb_idx;
  fu_idx_t               arb_fu;

  // Eligibility: requesting, valid FU id, FU ready, and not the entry granted last cycle
  // (wakeup clears that request one cycle late).
  always_comb begin
    eligible = '0;
    fu_sel   = '0;
    for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
      fu_sel = bus.entry_fu[j*FU_W +: FU_W];
      eligible[j] = bus.request_vector[j]
                    && (32'(fu_sel) < NUM_FUS)
                    && bus.fu_ready[fu_sel]
                    && !(grant_en_q && (grant_index_q == rs_idx_t'(j)));
    end
  end

  issue_select_unit_rr_arbiter #(
    .N (RS_ENTRIES)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  assign arb_fu = bus.entry_fu[32'(arb_idx)*FU_W +: FU_W];

  // Grant registers and round-robin pointer; flush wins over any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_en_q    <= 1'b0;
      grant_index_q <= '0;
      grant_fu_q    <= '0;
      rr_ptr_q      <= '0;
    end else if (bus.flush) begin
      grant_en_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else if (arb_valid) begin
      grant_en_q    <= 1'b1;
      grant_index_q <= arb_idx;
      grant_fu_q    <= arb_fu;
      rr_ptr_q      <= next_idx(arb_idx);
    end else begin
      grant_en_q <= 1'b0;
    end
  end

  assign bus.grant_en    = grant_en_q;
  assign bus.grant_index = grant_index_q;
  assign bus.grant_fu    = grant_fu_q;

`ifdef SELECT_PERF_CNT_EN
  logic [31:0]           perf_grant_cnt_q;
  logic [31:0]           perf_block_cnt_q;
  logic [RS_ENTRIES-1:0] fu_busy;
  fu_idx_t               busy_fu_sel;
  logic                  block_cycle;

  // Entries that would be eligible but for a busy FU.
  always_comb begin
    fu_busy     = '0;
    busy_fu_sel = '0;
    for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
      busy_fu_sel = bus.entry_fu[j*FU_W +: FU_W];
      fu_busy[j]  = bus.request_vector[j]
                    && (32'(busy_fu_sel) < NUM_FUS)
                    && !bus.fu_ready[busy_fu_sel]
                    && !(grant_en_q && (grant_index_q == rs_idx_t'(j)));
    end
  end

  assign block_cycle = (|bus.request_vector) && !arb_valid && (|fu_busy);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt_q <= '0;
      perf_block_cnt_q <= '0;
    end else begin
      if (grant_en_q && (perf_grant_cnt_q != 32'hFFFF_FFFF)) begin
        perf_grant_cnt_q <= perf_grant_cnt_q + 32'd1;
      end
      if (block_cycle && (perf_block_cnt_q != 32'hFFFF_FFFF)) begin
        perf_block_cnt_q <= perf_block_cnt_q + 32'd1;
      end
    end
  end

  assign bus.perf_grant_cnt = perf_grant_cnt_q;
  assign bus.perf_block_cnt = perf_block_cnt_q;
`else
  assign bus.perf_grant_cnt = '0;
  assign bus.perf_block_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_select_unit.sv
// Scoreboard bench for issue_select_unit: stimulus pushes expected grants, a monitor pops/compares.
module tb_issue_select_unit;
  import issue_select_unit_pkg::*;

  typedef struct {
    logic    en;
    rs_idx_t idx;
    fu_idx_t fu;
    logic    chk_idx;
    string   name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_select_unit_if bus ();

  issue_select_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef SELECT_PERF_CNT_EN
  localparam int unsigned ExpBlock = 3;
  localparam int unsigned ExpGrant = 6;
`else
  localparam int unsigned ExpBlock = 0;
  localparam int unsigned ExpGrant = 0;
`endif

  // Monitor: one expectation per clock, sampled 1ns after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ((bus.grant_en !== mon_e.en) ||
          (mon_e.chk_idx && ((bus.grant_index !== mon_e.idx) || (bus.grant_fu !== mon_e.fu))))
      begin
        n_fail++;
        $display("FAIL %s: got en=%b idx=%0d fu=%0d, expected en=%b idx=%0d fu=%0d (idx checked=%b)",
                 mon_e.name, bus.grant_en, bus.grant_index, bus.grant_fu,
                 mon_e.en, mon_e.idx, mon_e.fu, mon_e.chk_idx);
      end
    end
  end

  // Drive one cycle of inputs and queue the grant expected after the next edge.
  task automatic step(input string name, input logic r, input logic fl,
                      input logic [RS_ENTRIES-1:0] req, input logic [RS_ENTRIES*FU_W-1:0] efu,
                      input logic [NUM_FUS-1:0] fr, input logic en, input int unsigned idx,
                      input int unsigned fu, input logic chk_idx);
    exp_t e;
    @(negedge clk);
    rst                = r;
    bus.flush          = fl;
    bus.request_vector = req;
    bus.entry_fu       = efu;
    bus.fu_ready       = fr;
    e.en      = en;
    e.idx     = rs_idx_t'(idx);
    e.fu      = fu_idx_t'(fu);
    e.chk_idx = chk_idx;
    e.name    = name;
    exp_q.push_back(e);
  endtask

  // Check perf counters after the edge that consumes the last queued step.
  task automatic check_perf(input string name, input int unsigned g, input int unsigned b);
    @(posedge clk);
    #2;
    n_checks++;
    if ((bus.perf_grant_cnt !== g) || (bus.perf_block_cnt !== b)) begin
      n_fail++;
      $display("FAIL %s: got grant_cnt=%0d block_cnt=%0d, expected grant_cnt=%0d block_cnt=%0d",
               name, bus.perf_grant_cnt, bus.perf_block_cnt, g, b);
    end
  endtask

  initial begin
    int waited;
    bus.flush          = 1'b0;
    bus.request_vector = '0;
    bus.entry_fu       = '0;
    bus.fu_ready       = '1;

    // Reset with all requests high.
    step("reset0", 1, 0, 8'hFF, 8'h00, 2'b11, 0, 0, 0, 1);
    step("reset1", 1, 0, 8'hFF, 8'h00, 2'b11, 0, 0, 0, 1);
    check_perf("perf_reset", 0, 0);

    // Two requesters alternate.
    step("alt_0", 0, 0, 8'h05, 8'h00, 2'b11, 1, 0, 0, 1);
    step("alt_2", 0, 0, 8'h05, 8'h00, 2'b11, 1, 2, 0, 1);
    step("alt_0b", 0, 0, 8'h05, 8'h00, 2'b11, 1, 0, 0, 1);
    step("alt_2b", 0, 0, 8'h05, 8'h00, 2'b11, 1, 2, 0, 1);

    // Single requester: last-grant mask forces a bubble.
    step("single_1", 0, 0, 8'h02, 8'h00, 2'b11, 1, 1, 0, 1);
    step("single_mask", 0, 0, 8'h02, 8'h00, 2'b11, 0, 1, 0, 1);
    step("single_1b", 0, 0, 8'h02, 8'h00, 2'b11, 1, 1, 0, 1);

    // No requests: index/fu hold.
    step("idle_hold", 0, 0, 8'h00, 8'h00, 2'b11, 0, 1, 0, 1);

    // FU backpressure: entry 3 on FU1, FU1 busy.
    step("blocked_a", 0, 0, 8'h08, 8'h08, 2'b01, 0, 1, 0, 1);
    step("blocked_b", 0, 0, 8'h08, 8'h08, 2'b01, 0, 1, 0, 1);
    step("blocked_c", 0, 0, 8'h08, 8'h08, 2'b01, 0, 1, 0, 1);
    check_perf("perf_blocked", ExpGrant, ExpBlock);
    step("unblocked_3", 0, 0, 8'h08, 8'h08, 2'b11, 1, 3, 1, 1);

    // Pointer wrap: grant 6 leaves pointer at 7, then 7 and 1.
    step("grant_6", 0, 0, 8'h40, 8'h00, 2'b11, 1, 6, 0, 1);
    step("wrap_7", 0, 0, 8'h82, 8'h00, 2'b11, 1, 7, 0, 1);
    step("wrap_1", 0, 0, 8'h82, 8'h00, 2'b11, 1, 1, 0, 1);

    // Flush kills the grant and resets the pointer.
    step("flush", 0, 1, 8'hFF, 8'h00, 2'b11, 0, 1, 0, 1);
    step("post_flush_0", 0, 0, 8'hFF, 8'h00, 2'b11, 1, 0, 0, 1);
    step("post_flush_1", 0, 0, 8'hFF, 8'h00, 2'b11, 1, 1, 0, 1);

    // Mid-operation reset clears outputs and pointer.
    step("mid_reset", 1, 0, 8'hFF, 8'h00, 2'b11, 0, 0, 0, 1);
    step("post_reset_0", 0, 0, 8'hFF, 8'h00, 2'b11, 1, 0, 0, 1);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
